imm_decode_stage: RTL
=====================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64, other values SHALL fail elaboration.
REQ-002 Parameter EN_RV64I, default 0, when 1 decodes OP-IMM-32 (0011011) as I-type; it SHALL be forced to 0 when XLEN=32.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept an instruction.
REQ-007 in_inst  input  32  raw instruction word.
REQ-008 in_pc  input  XLEN  instruction address.
REQ-009 flush  input  1  discard all buffered entries.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_type  output  3  immediate type: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 illegal.
REQ-014 out_target  output  XLEN  in_pc + out_imm, modulo 2^XLEN.
REQ-015 out_pc and out_inst  output  XLEN/32  pass-through of the accepted entry.
REQ-016 illegal_cnt  output  16  saturating count of accepted illegal instructions.

Function
REQ-017 Type SHALL be decoded from in_inst[6:0] at acceptance; an external type select SHALL NOT exist.
REQ-018 Decode: 0010011/0000011/1100111/0001111 -> I; 1110011 -> Z if inst[14]=1, else I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; 0011011 -> I and 0111011 -> R only when EN_RV64I=1.
REQ-019 Any other opcode, or inst[1:0] != 2'b11, SHALL give type 7 with imm 0.
REQ-020 I: sign-extend inst[31:20]; S: sign-extend {inst[31:25],inst[11:7]}; B: sign-extend {inst[31],inst[7],inst[30:25],inst[11:8],0}; J: sign-extend {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-021 U: {inst[31:12],12'b0}, sign-extended from bit 31 to XLEN; Z: zero-extend inst[19:15]; R: 0.
REQ-022 Immediate, type and target SHALL be computed before storage; the buffer holds decoded results.
REQ-023 Storage SHALL be a 2-entry FIFO; in_ready = (count < 2), out_valid = (count > 0), both derived from registered state only.
REQ-024 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-025 Latency SHALL be 1 cycle: an entry accepted in cycle N is presented in cycle N+1.
REQ-026 Push and pop in the same cycle with count=1 SHALL keep count=1, allowing full throughput.
REQ-027 When count=2, in_ready=0; the input SHALL NOT be captured even if pop occurs that cycle.
REQ-028 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-029 flush SHALL set count=0 next cycle; a push in the same cycle SHALL be dropped, and illegal_cnt SHALL NOT count it.
REQ-030 illegal_cnt SHALL increment once per pushed type-7 entry, SHALL saturate at 0xFFFF, and SHALL be unaffected by flush.
REQ-031 Pointers SHALL wrap modulo 2.

Reset
REQ-032 On rst: count=0, out_valid=0, in_ready=1 in the following cycle, pointers=0, illegal_cnt=0.
REQ-033 Data registers need no reset; out_imm/out_type/out_target are don't-care while out_valid=0.
REQ-034 rst mid-stream SHALL discard buffered entries and SHALL take priority over flush and push.

Verification
REQ-035 XLEN=32, push 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> next cycle out_type=1, out_imm=0xFFFFFFFF, out_target=0x000000FF.
REQ-036 Push 0xFE000EE3 (beq x0,x0,-4), pc 0x100 -> out_type=3, out_imm=0xFFFFFFFC, out_target=0x000000FC; with XLEN=64, out_imm=0xFFFFFFFFFFFFFFFC.
REQ-037 Push 0x123452B7 (lui) -> type 4, imm 0x12345000; push 0x0052D073 (csrrwi, uimm 5) -> type 6, imm 0x5.
REQ-038 Hold out_ready=0 and push 3 back-to-back -> in_ready drops after 2 pushes, 3rd not accepted, head stable; release -> entries drain in order, one per cycle.
REQ-039 Push 0x00000000 three times then flush concurrently with a 4th push -> illegal_cnt=3, count=0 after flush; separately, preload illegal_cnt to 0xFFFF and push illegal -> stays 0xFFFF.
REQ-040 Assert rst with 2 entries buffered -> next cycle out_valid=0, in_ready=1, illegal_cnt=0.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Decode stage: extracts the RISC-V immediate, its format and the pc-relative
// target at acceptance, then buffers the decoded result in a 2-entry FIFO.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit EN_RV64I = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [15:0]     illegal_cnt
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    // OP-IMM-32 / OP-32 only exist on a 64-bit datapath.
    localparam bit RV64 = (XLEN == 64) && EN_RV64I;

    localparam logic [2:0] TY_R   = 3'd0;
    localparam logic [2:0] TY_I   = 3'd1;
    localparam logic [2:0] TY_S   = 3'd2;
    localparam logic [2:0] TY_B   = 3'd3;
    localparam logic [2:0] TY_U   = 3'd4;
    localparam logic [2:0] TY_J   = 3'd5;
    localparam logic [2:0] TY_Z   = 3'd6;
    localparam logic [2:0] TY_ILL = 3'd7;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      ty;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t          entry_q [2];
    entry_t          entry_d [2];
    entry_t          dec;
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [15:0]     illegal_cnt_q, illegal_cnt_d;
    logic            push, pop;
    logic [2:0]      dec_type;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                  in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                  in_inst[30:21], 1'b0}));
    assign imm_z = XLEN'(in_inst[19:15]);

    always_comb begin
        dec_type = TY_ILL;
        if (in_inst[1:0] == 2'b11) begin
            case (in_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: dec_type = TY_I;
                7'b1110011: dec_type = in_inst[14] ? TY_Z : TY_I;
                7'b0100011: dec_type = TY_S;
                7'b1100011: dec_type = TY_B;
                7'b0110111, 7'b0010111: dec_type = TY_U;
                7'b1101111: dec_type = TY_J;
                7'b0110011: dec_type = TY_R;
                7'b0011011: dec_type = RV64 ? TY_I : TY_ILL;
                7'b0111011: dec_type = RV64 ? TY_R : TY_ILL;
                default:    dec_type = TY_ILL;
            endcase
        end
    end

    always_comb begin
        case (dec_type)
            TY_I:    dec_imm = imm_i;
            TY_S:    dec_imm = imm_s;
            TY_B:    dec_imm = imm_b;
            TY_U:    dec_imm = imm_u;
            TY_J:    dec_imm = imm_j;
            TY_Z:    dec_imm = imm_z;
            default: dec_imm = '0;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.inst   = in_inst;
        dec.pc     = in_pc;
        dec.imm    = dec_imm;
        dec.ty     = dec_type;
        dec.target = in_pc + dec_imm;
    end

    // Handshake: a beat transfers on a rising edge where valid && ready are
    // both high; ready never depends on valid, and both come straight from
    // registered occupancy so neither side sees a combinational path.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        illegal_cnt_d = illegal_cnt_q;
        entry_d       = entry_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            if (push) begin
                entry_d[wr_ptr_q] = dec;
                if (dec_type == TY_ILL && illegal_cnt_q != 16'hFFFF) begin
                    illegal_cnt_d = illegal_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            illegal_cnt_q <= 16'd0;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Payload is qualified by count, so it carries no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign out_inst    = entry_q[rd_ptr_q].inst;
    assign out_pc      = entry_q[rd_ptr_q].pc;
    assign out_imm     = entry_q[rd_ptr_q].imm;
    assign out_type    = entry_q[rd_ptr_q].ty;
    assign out_target  = entry_q[rd_ptr_q].target;
    assign illegal_cnt = illegal_cnt_q;

endmodule
